// File: rtl/down_counter_n_pkg.sv
// Shared encodings for the down_counter_n block: the latched counting mode
// and the two-state run/idle FSM.
package down_counter_n_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_RELOAD  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/down_counter_n_dec_core.sv
// Combinational WIDTH-bit subtractor: diff = a - b (mod 2^WIDTH),
// borrow set when b > a.
module dec_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // One extra bit on the operands turns the carry-out into the borrow flag.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/down_counter_n.sv
// Loadable down counter with wrap, saturate, reload and one-shot modes,
// driven by a small IDLE/RUN FSM.
module down_counter_n
  import down_counter_n_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [1:0]        mode,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              borrow,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  state_e            state_q,  state_d;
  mode_e             mode_q,   mode_d;
  logic [WIDTH-1:0]  reload_q, reload_d;
  logic [WIDTH-1:0]  count_q,  count_d;
  logic              borrow_q, borrow_d;
  logic              done_q,   done_d;

  logic [WIDTH-1:0]  sub_diff;
  logic              sub_borrow;

  dec_core #(.WIDTH(WIDTH)) u_dec_core (
    .a      (count_q),
    .b      (WIDTH'(step)),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    mode_d   = mode_q;
    reload_d = reload_q;
    count_d  = count_q;
    borrow_d = 1'b0;
    done_d   = 1'b0;

    if (load) begin
      state_d  = ST_RUN;
      mode_d   = mode_e'(mode);
      reload_d = load_val;
      count_d  = load_val;
    end else if (state_q == ST_RUN && en && step != '0) begin
      case (mode_q)
        MODE_WRAP: begin
          count_d  = sub_diff;
          borrow_d = sub_borrow;
        end
        MODE_SAT: begin
          count_d  = sub_borrow ? '0 : sub_diff;
          borrow_d = sub_borrow;
        end
        MODE_RELOAD: begin
          count_d  = sub_borrow ? reload_q : sub_diff;
          borrow_d = sub_borrow;
        end
        MODE_ONESHOT: begin
          // Completion covers both an exact hit of zero and an overshoot.
          if (sub_borrow || sub_diff == '0) begin
            count_d  = '0;
            borrow_d = sub_borrow;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            count_d = sub_diff;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_WRAP;
      reload_q <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign count  = count_q;
  assign borrow = borrow_q;
  assign done   = done_q;
  assign zero   = (count_q == '0);
  assign busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_counter_n.sv
// Directed self-checking bench for down_counter_n (WIDTH=8, STEP_W=4):
// one task per mode/scenario with hand-computed expectations.
module tb_down_counter_n;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk;
  logic              rst_n;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [1:0]        mode;
  logic              en;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              borrow;
  logic              zero;
  logic              busy;
  logic              done;

  int n_total = 0;
  int n_pass  = 0;

  down_counter_n #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .en       (en),
    .step     (step),
    .count    (count),
    .borrow   (borrow),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; return 1 time unit after it so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v, input logic [1:0] m);
    load = 1'b1; load_val = v; mode = m; en = 1'b0; step = '0;
    tick();
    load = 1'b0;
  endtask

  task automatic dec(input logic e, input logic [STEP_W-1:0] s);
    en = e; step = s;
    tick();
  endtask

  // Observed vector is {count, borrow, done, busy, zero}.
  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; load_val = '0; mode = 2'b00; en = 1'b0; step = '0;
    #23;
    n_total++;
    if ({count, borrow, done, busy, zero} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state: got %h want %h", {count, borrow, done, busy, zero}, {8'd0, 4'b0001});
    else n_pass++;
    rst_n = 1'b1;
    #4;
    dec(1'b1, 4'd3);
    n_total++;
    if ({count, borrow, busy} !== {8'd0, 1'b0, 1'b0})
      $display("FAIL idle_ignores_en: got count=%0d borrow=%b busy=%b want 0 0 0", count, borrow, busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_load(8'd0, 2'b00);
    n_total++;
    if ({count, borrow, busy, zero} !== {8'd0, 1'b0, 1'b1, 1'b1})
      $display("FAIL wrap_load: got count=%0d borrow=%b busy=%b zero=%b want 0 0 1 1", count, borrow, busy, zero);
    else n_pass++;
    dec(1'b1, 4'd1);
    n_total++;
    if ({count, borrow, zero} !== {8'd255, 1'b1, 1'b0})
      $display("FAIL wrap_underflow: got count=%0d borrow=%b zero=%b want 255 1 0", count, borrow, zero);
    else n_pass++;
    dec(1'b1, 4'd1);
    n_total++;
    if ({count, borrow} !== {8'd254, 1'b0})
      $display("FAIL wrap_next: got count=%0d borrow=%b want 254 0", count, borrow);
    else n_pass++;
    dec(1'b0, 4'd7);
    n_total++;
    if ({count, borrow} !== {8'd254, 1'b0})
      $display("FAIL wrap_en_low_hold: got count=%0d borrow=%b want 254 0", count, borrow);
    else n_pass++;
    dec(1'b1, 4'd0);
    n_total++;
    if ({count, borrow} !== {8'd254, 1'b0})
      $display("FAIL wrap_step0_hold: got count=%0d borrow=%b want 254 0", count, borrow);
    else n_pass++;
    dec(1'b1, 4'd15);
    n_total++;
    if ({count, borrow} !== {8'd239, 1'b0})
      $display("FAIL wrap_step15: got count=%0d borrow=%b want 239 0", count, borrow);
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_load(8'd3, 2'b01);
    dec(1'b1, 4'd5);
    n_total++;
    if ({count, borrow, zero} !== {8'd0, 1'b1, 1'b1})
      $display("FAIL sat_clamp: got count=%0d borrow=%b zero=%b want 0 1 1", count, borrow, zero);
    else n_pass++;
    dec(1'b1, 4'd5);
    n_total++;
    if ({count, borrow} !== {8'd0, 1'b1})
      $display("FAIL sat_repulse: got count=%0d borrow=%b want 0 1", count, borrow);
    else n_pass++;
    dec(1'b1, 4'd0);
    n_total++;
    if ({count, borrow, busy} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL sat_step0: got count=%0d borrow=%b busy=%b want 0 0 1", count, borrow, busy);
    else n_pass++;
  endtask

  task automatic test_reload();
    do_load(8'd10, 2'b10);
    dec(1'b1, 4'd4);
    n_total++;
    if ({count, borrow, busy} !== {8'd6, 1'b0, 1'b1})
      $display("FAIL reload_1: got count=%0d borrow=%b busy=%b want 6 0 1", count, borrow, busy);
    else n_pass++;
    dec(1'b1, 4'd4);
    n_total++;
    if ({count, borrow, busy} !== {8'd2, 1'b0, 1'b1})
      $display("FAIL reload_2: got count=%0d borrow=%b busy=%b want 2 0 1", count, borrow, busy);
    else n_pass++;
    dec(1'b1, 4'd4);
    n_total++;
    if ({count, borrow, busy} !== {8'd10, 1'b1, 1'b1})
      $display("FAIL reload_3: got count=%0d borrow=%b busy=%b want 10 1 1", count, borrow, busy);
    else n_pass++;
    dec(1'b1, 4'd4);
    n_total++;
    if ({count, borrow, busy} !== {8'd6, 1'b0, 1'b1})
      $display("FAIL reload_4: got count=%0d borrow=%b busy=%b want 6 0 1", count, borrow, busy);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    do_load(8'd9, 2'b11);
    dec(1'b1, 4'd4);
    n_total++;
    if ({count, done, busy} !== {8'd5, 1'b0, 1'b1})
      $display("FAIL oneshot_partial: got count=%0d done=%b busy=%b want 5 0 1", count, done, busy);
    else n_pass++;
    dec(1'b1, 4'd5);
    n_total++;
    if ({count, borrow, done, busy} !== {8'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL oneshot_exact: got count=%0d borrow=%b done=%b busy=%b want 0 0 1 0", count, borrow, done, busy);
    else n_pass++;
    dec(1'b1, 4'd5);
    n_total++;
    if ({count, borrow, done, busy} !== {8'd0, 1'b0, 1'b0, 1'b0})
      $display("FAIL oneshot_after: got count=%0d borrow=%b done=%b busy=%b want 0 0 0 0", count, borrow, done, busy);
    else n_pass++;
    do_load(8'd3, 2'b11);
    dec(1'b1, 4'd5);
    n_total++;
    if ({count, borrow, done, busy} !== {8'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL oneshot_overshoot: got count=%0d borrow=%b done=%b busy=%b want 0 1 1 0", count, borrow, done, busy);
    else n_pass++;
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 8'd20; mode = 2'b00; en = 1'b1; step = 4'd3;
    tick();
    load = 1'b0;
    n_total++;
    if ({count, borrow, busy} !== {8'd20, 1'b0, 1'b1})
      $display("FAIL load_priority: got count=%0d borrow=%b busy=%b want 20 0 1", count, borrow, busy);
    else n_pass++;
    dec(1'b1, 4'd3);
    n_total++;
    if ({count, borrow} !== {8'd17, 1'b0})
      $display("FAIL after_load_dec: got count=%0d borrow=%b want 17 0", count, borrow);
    else n_pass++;
    // A load while already running restarts from the new value.
    load = 1'b1; load_val = 8'd40; mode = 2'b00; en = 1'b1; step = 4'd1;
    tick();
    load = 1'b0;
    n_total++;
    if ({count, busy} !== {8'd40, 1'b1})
      $display("FAIL restart_load: got count=%0d busy=%b want 40 1", count, busy);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({count, borrow, done, busy} !== {8'd0, 1'b0, 1'b0, 1'b0})
      $display("FAIL async_reset_midrun: got count=%0d borrow=%b done=%b busy=%b want 0 0 0 0", count, borrow, done, busy);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    dec(1'b1, 4'd2);
    dec(1'b1, 4'd2);
    n_total++;
    if ({count, borrow, busy} !== {8'd0, 1'b0, 1'b0})
      $display("FAIL post_reset_idle: got count=%0d borrow=%b busy=%b want 0 0 0", count, borrow, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_reload();
    test_oneshot();
    test_priority();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
